// File: rtl/wb_commit_stage_if.sv
// MEM-to-WB bundle: MEM-stage results and flush in, register bank write port and
// forwarding/error status out. The slave modport is the commit stage's view.
interface wb_commit_stage_if;
  logic        mem_valid;
  logic        mem_reg_wen;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_load_word;
  logic        flush;
  logic        regWEn;
  logic [4:0]  addr_D;
  logic [31:0] data_D;
  logic        fwd_valid;
  logic        misalign_err;

  modport master (
    output mem_valid, mem_reg_wen, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_pc_plus4, mem_load_word, flush,
    input  regWEn, addr_D, data_D, fwd_valid, misalign_err
  );

  modport slave (
    input  mem_valid, mem_reg_wen, mem_rd, mem_wb_sel, mem_funct3,
           mem_alu_result, mem_pc_plus4, mem_load_word, flush,
    output regWEn, addr_D, data_D, fwd_valid, misalign_err
  );
endinterface

// File: rtl/wb_commit_stage.sv
// MEM/WB register and register-bank write driver with load alignment and x0/misalign squash.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_commit_stage #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
) (
  input  logic               clock,
  input  logic               rst_n,
  wb_commit_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retire_count
`endif
);

  if (XLEN != 32 || RETIRE_W < 1) begin : g_unsupported_cfg
    $error("wb_commit_stage: only XLEN=32 and RETIRE_W>=1 are supported");
  end

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  logic [1:0]      addr_lo;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_val;
  logic            misaligned_d;
  logic            capture_d;
  logic            regwen_d;
  logic [XLEN-1:0] data_d;
  logic            misalign_err_d;

  logic            regwen_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic            misalign_err_q;

  always_comb begin
    addr_lo   = bus.mem_alu_result[1:0];
    load_byte = 8'(bus.mem_load_word >> {addr_lo, 3'b000});
    load_half = addr_lo[1] ? bus.mem_load_word[31:16] : bus.mem_load_word[15:0];

    case (bus.mem_funct3)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_val = {24'd0, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b101:  load_val = {16'd0, load_half};
      default: load_val = bus.mem_load_word;
    endcase

    misaligned_d = 1'b0;
    if (bus.mem_wb_sel == SEL_LOAD) begin
      case (bus.mem_funct3)
        3'b001, 3'b101: misaligned_d = addr_lo[0];
        3'b010:         misaligned_d = (addr_lo != 2'b00);
        default:        misaligned_d = 1'b0;
      endcase
    end

    // Reserved select 11 falls through to the ALU result.
    case (bus.mem_wb_sel)
      SEL_LOAD: data_d = load_val;
      SEL_PC4:  data_d = bus.mem_pc_plus4;
      default:  data_d = bus.mem_alu_result;
    endcase

    capture_d      = bus.mem_valid & ~bus.flush;
    regwen_d       = capture_d & bus.mem_reg_wen & (bus.mem_rd != 5'd0) & ~misaligned_d;
    misalign_err_d = capture_d & misaligned_d;
  end

  // Write enable and error are registered already-qualified so the bank sees clean flops.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      regwen_q       <= 1'b0;
      addr_q         <= 5'd0;
      data_q         <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      regwen_q       <= regwen_d;
      addr_q         <= bus.mem_rd;
      data_q         <= data_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus.regWEn       = regwen_q;
  assign bus.addr_D       = addr_q;
  assign bus.data_D       = data_q;
  assign bus.fwd_valid    = regwen_q;
  assign bus.misalign_err = misalign_err_q;

`ifdef WB_RETIRE_CNT_EN
  logic                wb_valid_q;
  logic                wb_misaligned_q;
  logic [RETIRE_W-1:0] retire_d;
  logic [RETIRE_W-1:0] retire_q;

  // Counts instructions as they sit in WB, including x0 and non-writing ones.
  always_comb begin
    retire_d = retire_q;
    if (wb_valid_q && !wb_misaligned_q) begin
      retire_d = retire_q + RETIRE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_misaligned_q <= 1'b0;
      retire_q        <= '0;
    end else begin
      wb_valid_q      <= capture_d;
      wb_misaligned_q <= misaligned_d;
      retire_q        <= retire_d;
    end
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed table-driven bench for wb_commit_stage plus reset and retire-counter sequences.
module tb_wb_commit_stage;
  localparam int RW = 4;
  localparam logic [31:0] WORD = 32'h80FF7F01;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  wb_commit_stage_if bus ();
`ifdef WB_RETIRE_CNT_EN
  logic [RW-1:0] retire_count;
`endif

  wb_commit_stage #(.XLEN(32), .RETIRE_W(RW)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  typedef struct {
    logic        valid;
    logic        wen;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        flush;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_mis;
    logic        chk_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[25];

  function automatic vec_t mk(logic valid, logic wen, logic [4:0] rd, logic [1:0] sel,
                              logic [2:0] f3, logic [31:0] alu, logic [31:0] pc4, logic flush,
                              logic e_wen, logic [4:0] e_addr, logic [31:0] e_data,
                              logic e_mis, logic chk_data);
    vec_t v;
    v.valid = valid; v.wen = wen; v.rd = rd; v.sel = sel; v.f3 = f3;
    v.alu = alu; v.pc4 = pc4; v.flush = flush;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
    v.e_mis = e_mis; v.chk_data = chk_data;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.mem_valid      = v.valid;
    bus.mem_reg_wen    = v.wen;
    bus.mem_rd         = v.rd;
    bus.mem_wb_sel     = v.sel;
    bus.mem_funct3     = v.f3;
    bus.mem_alu_result = v.alu;
    bus.mem_pc_plus4   = v.pc4;
    bus.mem_load_word  = WORD;
    bus.flush          = v.flush;
  endtask

  task automatic step(input vec_t v);
    @(negedge clock);
    drive(v);
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_regWEn"}, 0, 32'(bus.regWEn), 32'd0);
    check({nm, "_addr"},   0, 32'(bus.addr_D), 32'd0);
    check({nm, "_data"},   0, bus.data_D, 32'd0);
    check({nm, "_mis"},    0, 32'(bus.misalign_err), 32'd0);
  endtask

  initial begin
    vec_t bubble;
    bubble = mk(0,0,5'd0,2'b00,3'b000,32'h0,32'h0,0, 0,5'd0,32'h0,0,1);

    //            vld wen rd    sel    f3      alu          pc4         fl  ewen eaddr  edata          emis chk
    vecs[0]  = mk(1, 1, 5'd5,  2'b00, 3'b000, 32'h1234,    32'h0,      0,  1, 5'd5,  32'h00001234, 0, 1);
    vecs[1]  = bubble;
    vecs[2]  = mk(1, 1, 5'd1,  2'b01, 3'b000, 32'h101,     32'h0,      0,  1, 5'd1,  32'h0000007F, 0, 1);
    vecs[3]  = mk(1, 1, 5'd2,  2'b01, 3'b100, 32'h102,     32'h0,      0,  1, 5'd2,  32'h000000FF, 0, 1);
    vecs[4]  = mk(1, 1, 5'd3,  2'b01, 3'b001, 32'h102,     32'h0,      0,  1, 5'd3,  32'hFFFF80FF, 0, 1);
    vecs[5]  = mk(1, 1, 5'd4,  2'b01, 3'b101, 32'h102,     32'h0,      0,  1, 5'd4,  32'h000080FF, 0, 1);
    vecs[6]  = mk(1, 1, 5'd5,  2'b01, 3'b010, 32'h100,     32'h0,      0,  1, 5'd5,  32'h80FF7F01, 0, 1);
    vecs[7]  = mk(1, 1, 5'd6,  2'b01, 3'b000, 32'h103,     32'h0,      0,  1, 5'd6,  32'hFFFFFF80, 0, 1);
    vecs[8]  = mk(1, 1, 5'd6,  2'b01, 3'b001, 32'h100,     32'h0,      0,  1, 5'd6,  32'h00007F01, 0, 1);
    vecs[9]  = mk(1, 1, 5'd7,  2'b01, 3'b010, 32'h102,     32'h0,      0,  0, 5'd7,  32'h0,        1, 0);
    vecs[10] = bubble;
    vecs[11] = mk(1, 1, 5'd8,  2'b01, 3'b001, 32'h101,     32'h0,      0,  0, 5'd8,  32'h0,        1, 0);
    vecs[12] = mk(1, 1, 5'd8,  2'b01, 3'b101, 32'h103,     32'h0,      0,  0, 5'd8,  32'h0,        1, 0);
    vecs[13] = mk(1, 1, 5'd9,  2'b00, 3'b000, 32'h9999,    32'h0,      0,  1, 5'd9,  32'h00009999, 0, 1);
    vecs[14] = mk(1, 1, 5'd0,  2'b00, 3'b000, 32'hDEAD,    32'h0,      0,  0, 5'd0,  32'h0000DEAD, 0, 1);
    vecs[15] = mk(1, 1, 5'd10, 2'b00, 3'b000, 32'h55,      32'h0,      1,  0, 5'd10, 32'h00000055, 0, 1);
    vecs[16] = mk(1, 1, 5'd7,  2'b01, 3'b010, 32'h101,     32'h0,      1,  0, 5'd7,  32'h0,        0, 0);
    vecs[17] = mk(1, 1, 5'd1,  2'b10, 3'b000, 32'h1,       32'h2000,   0,  1, 5'd1,  32'h00002000, 0, 1);
    vecs[18] = mk(1, 1, 5'd2,  2'b11, 3'b000, 32'h3333,    32'h4444,   0,  1, 5'd2,  32'h00003333, 0, 1);
    vecs[19] = mk(1, 1, 5'd3,  2'b01, 3'b011, 32'h103,     32'h0,      0,  1, 5'd3,  32'h80FF7F01, 0, 1);
    vecs[20] = mk(1, 0, 5'd4,  2'b00, 3'b000, 32'h7,       32'h0,      0,  0, 5'd4,  32'h00000007, 0, 1);
    vecs[21] = mk(1, 1, 5'd11, 2'b00, 3'b000, 32'h1,       32'h0,      0,  1, 5'd11, 32'h00000001, 0, 1);
    vecs[22] = mk(1, 1, 5'd11, 2'b00, 3'b000, 32'h2,       32'h0,      0,  1, 5'd11, 32'h00000002, 0, 1);
    vecs[23] = mk(1, 1, 5'd11, 2'b00, 3'b000, 32'h3,       32'h0,      0,  1, 5'd11, 32'h00000003, 0, 1);
    vecs[24] = bubble;

    // Reset state and release with no pending capture.
    drive(bubble);
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_regWEn", 0, 32'(bus.regWEn), 32'd0);
    @(posedge clock); #1;
    check("post_reset_regWEn", 1, 32'(bus.regWEn), 32'd0);

    for (int i = 0; i < 25; i++) begin
      step(vecs[i]);
      $display("vec %0d: regWEn=%0b addr_D=%0d data_D=0x%08h misalign_err=%0b",
               i, bus.regWEn, bus.addr_D, bus.data_D, bus.misalign_err);
      check("regWEn",    i, 32'(bus.regWEn),       32'(vecs[i].e_wen));
      check("fwd_valid", i, 32'(bus.fwd_valid),    32'(vecs[i].e_wen));
      check("addr_D",    i, 32'(bus.addr_D),       32'(vecs[i].e_addr));
      check("mis_err",   i, 32'(bus.misalign_err), 32'(vecs[i].e_mis));
      if (vecs[i].chk_data) check("data_D", i, bus.data_D, vecs[i].e_data);
    end

    // Reset asserted mid-cycle while a write is presented.
    step(mk(1,1,5'd5,2'b00,3'b000,32'hAA,32'h0,0, 1,5'd5,32'hAA,0,1));
    $display("midreset pre: regWEn=%0b addr_D=%0d data_D=0x%08h", bus.regWEn, bus.addr_D, bus.data_D);
    check("mid_pre_regWEn", 0, 32'(bus.regWEn), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clock);
    drive(bubble);
    rst_n = 1'b1;
    #1;
    check("mid_release_regWEn", 0, 32'(bus.regWEn), 32'd0);
    @(posedge clock); #1;
    $display("midreset post: regWEn=%0b addr_D=%0d", bus.regWEn, bus.addr_D);
    check("mid_after_regWEn", 0, 32'(bus.regWEn), 32'd0);

`ifdef WB_RETIRE_CNT_EN
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("retire_reset", 0, 32'(retire_count), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3)
        step(mk(1,1,5'd1,2'b00,3'b000,32'h1,32'h0,1, 0,5'd0,32'h0,0,0));
      else if (i == 6)
        step(mk(1,1,5'd1,2'b01,3'b010,32'h102,32'h0,0, 0,5'd0,32'h0,0,0));
      else
        step(mk(1,1,5'd1,2'b00,3'b000,32'h1,32'h0,0, 0,5'd0,32'h0,0,0));
    end
    step(bubble);
    $display("retire after 10 ops: %0d", retire_count);
    check("retire_8", 0, 32'(retire_count), 32'd8);
    for (int i = 0; i < 8; i++) step(mk(1,0,5'd0,2'b00,3'b000,32'h0,32'h0,0, 0,5'd0,32'h0,0,0));
    step(bubble);
    $display("retire after wrap: %0d", retire_count);
    check("retire_wrap", 0, 32'(retire_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
